// File: rtl/aesl_deadlock_pkg.sv
// ============================================================================
// Module   : aesl_deadlock_pkg
// Purpose  : Shared types and defaults for the deadlock event recorder:
//            FSM state encoding, default event-entry layout, width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aesl_deadlock_pkg;

  localparam int DEF_PROC_NUM       = 2;
  localparam int DEF_LOG_DEPTH      = 8;
  localparam int DEF_CONFIRM_CYCLES = 16;
  localparam int DEF_TS_W           = 32;

  // Index width for an N-wide one-hot; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_PROC_NUM);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PENDING   = 2'd1,
    ST_CONFIRMED = 2'd2
  } dl_state_e;

  // Event entry at default widths; the top re-declares it at its own widths
  typedef struct packed {
    logic [DEF_IDX_W-1:0]    origin_idx;
    logic [DEF_PROC_NUM-1:0] dl_vec;
    logic [DEF_TS_W-1:0]     timestamp;
  } dl_entry_t;

endpackage

`default_nettype wire

// File: rtl/aesl_dl_event_fifo.sv
// ============================================================================
// Module   : aesl_dl_event_fifo
// Purpose  : Synchronous first-word-fall-through FIFO of event entries.
//            A push while full is accepted only when a pop frees a slot in
//            the same cycle; a pop while empty is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aesl_dl_event_fifo
  import aesl_deadlock_pkg::*;
#(
  parameter int  DEPTH   = DEF_LOG_DEPTH,
  parameter type ENTRY_T = dl_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  ENTRY_T        push_data_i,
  input  logic          pop_i,
  output ENTRY_T        head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  ENTRY_T        mem_q [DEPTH];

  logic do_pop;
  logic do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH = 2^AW)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/aesl_deadlock_event_recorder.sv
// ============================================================================
// Module   : aesl_deadlock_event_recorder
// Purpose  : Confirms a deadlock once the global flag has been high for
//            CONFIRM_CYCLES consecutive samples, logs a timestamped snapshot
//            of the first sample into a FIFO, and raises a stop request while
//            the confirmed deadlock persists.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aesl_deadlock_event_recorder
  import aesl_deadlock_pkg::*;
#(
  parameter int  PROC_NUM       = DEF_PROC_NUM,
  parameter int  LOG_DEPTH      = DEF_LOG_DEPTH,
  parameter int  CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
  parameter int  TS_W           = DEF_TS_W,
  localparam int IDX_W          = idx_width(PROC_NUM),
  localparam int CNT_W          = $clog2(LOG_DEPTH) + 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [PROC_NUM-1:0] dl_in_vec_i,
  input  logic                dl_detect_out_i,
  input  logic [PROC_NUM-1:0] origin_i,
  input  logic                token_clear_i,
  input  logic                rd_en_i,
  output logic                rd_valid_o,
  output logic [IDX_W-1:0]    rd_origin_idx_o,
  output logic [PROC_NUM-1:0] rd_dl_vec_o,
  output logic [TS_W-1:0]     rd_timestamp_o,
  output logic [CNT_W-1:0]    log_count_o,
  output logic                stop_req_o,
  output logic                overflow_o,
  output logic                origin_err_o,
  output logic [7:0]          spurious_cnt_o
);

  localparam int                CONF_W   = $clog2(CONFIRM_CYCLES);
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);

  typedef struct packed {
    logic [IDX_W-1:0]    origin_idx;
    logic [PROC_NUM-1:0] dl_vec;
    logic [TS_W-1:0]     timestamp;
  } entry_t;

  dl_state_e         state_q;
  dl_state_e         state_d;
  logic [CONF_W-1:0] conf_cnt_q;
  logic [TS_W-1:0]   ts_q;
  entry_t            cap_q;
  logic [7:0]        spur_q;
  logic              ovf_q;
  logic              oerr_q;

  logic              capture;
  logic              abort;
  logic              push_req;
  logic              stop_req;
  logic [IDX_W-1:0]  enc_idx;

  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // Lowest-set-bit encoder for the origin one-hot (0 when no bit is set)
  always_comb begin
    enc_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (origin_i[i]) enc_idx = IDX_W'(i);
    end
  end

  // FSM state register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic; token_clear only aborts an unconfirmed candidate
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dl_detect_out_i) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (!dl_detect_out_i || token_clear_i) state_d = ST_IDLE;
        else if (conf_cnt_q == CONF_LAST)      state_d = ST_CONFIRMED;
      end
      ST_CONFIRMED: begin
        if (!dl_detect_out_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; stop_req decodes the state so it drops with async reset
  always_comb begin
    capture  = (state_q == ST_IDLE) && dl_detect_out_i;
    abort    = (state_q == ST_PENDING) && (!dl_detect_out_i || token_clear_i);
    push_req = (state_q == ST_PENDING) && dl_detect_out_i && !token_clear_i &&
               (conf_cnt_q == CONF_LAST);
    stop_req = (state_q == ST_CONFIRMED);
  end

  // Free-running timestamp, confirm counter and first-sample snapshot
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ts_q       <= '0;
      conf_cnt_q <= '0;
      cap_q      <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (capture) begin
        conf_cnt_q       <= CONF_W'(1);
        cap_q.origin_idx <= enc_idx;
        cap_q.dl_vec     <= dl_in_vec_i;
        cap_q.timestamp  <= ts_q;
      end else if ((state_q == ST_PENDING) && !abort && !push_req) begin
        conf_cnt_q <= conf_cnt_q + CONF_W'(1);
      end
    end
  end

  // Spurious-candidate counter (saturating) and sticky error flags
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      spur_q <= '0;
      ovf_q  <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      if (abort && (spur_q != 8'hFF)) spur_q <= spur_q + 8'd1;
      if (push_req && fifo_full && !rd_en_i) ovf_q <= 1'b1;
      if (capture && !$onehot(origin_i)) oerr_q <= 1'b1;
    end
  end

  aesl_dl_event_fifo #(
    .DEPTH   (LOG_DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk_i       (clock_i),
    .rst_i       (reset_i),
    .push_i      (push_req),
    .push_data_i (cap_q),
    .pop_i       (rd_en_i),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Head fields read as zero while the log is empty
  assign rd_valid_o      = !fifo_empty;
  assign rd_origin_idx_o = fifo_empty ? '0 : head.origin_idx;
  assign rd_dl_vec_o     = fifo_empty ? '0 : head.dl_vec;
  assign rd_timestamp_o  = fifo_empty ? '0 : head.timestamp;
  assign log_count_o     = fifo_count;
  assign stop_req_o      = stop_req;
  assign overflow_o      = ovf_q;
  assign origin_err_o    = oerr_q;
  assign spurious_cnt_o  = spur_q;

endmodule

`default_nettype wire

// File: tb/tb_aesl_deadlock_event_recorder.sv
// ============================================================================
// Module   : tb_aesl_deadlock_event_recorder
// Purpose  : Directed self-checking bench for the deadlock event recorder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aesl_deadlock_event_recorder;

  localparam int PN = 2;
  localparam int LD = 8;
  localparam int CC = 16;
  localparam int TW = 32;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [PN-1:0] dl_vec;
  logic          dl;
  logic [PN-1:0] origin;
  logic          tc;
  logic          rd_en;
  logic          rd_valid;
  logic [IW-1:0] rd_idx;
  logic [PN-1:0] rd_vec;
  logic [TW-1:0] rd_ts;
  logic [3:0]    log_count;
  logic          stop;
  logic          ovf;
  logic          oerr;
  logic [7:0]    spur;

  int checks = 0;
  int errors = 0;
  int exp_spur = 0;
  logic [TW-1:0] tb_cyc;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [PN-1:0] vec;
    logic [TW-1:0] ts;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Reference cycle count: value the DUT timestamp should hold each cycle
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 1;
  end

  aesl_deadlock_event_recorder #(
    .PROC_NUM       (PN),
    .LOG_DEPTH      (LD),
    .CONFIRM_CYCLES (CC),
    .TS_W           (TW)
  ) dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .dl_in_vec_i     (dl_vec),
    .dl_detect_out_i (dl),
    .origin_i        (origin),
    .token_clear_i   (tc),
    .rd_en_i         (rd_en),
    .rd_valid_o      (rd_valid),
    .rd_origin_idx_o (rd_idx),
    .rd_dl_vec_o     (rd_vec),
    .rd_timestamp_o  (rd_ts),
    .log_count_o     (log_count),
    .stop_req_o      (stop),
    .overflow_o      (ovf),
    .origin_err_o    (oerr),
    .spurious_cnt_o  (spur)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] low_idx(input logic [PN-1:0] o);
    for (int i = 0; i < PN; i++) begin
      if (o[i]) return IW'(i);
    end
    return '0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    dl = 1'b0; tc = 1'b0; rd_en = 1'b0; origin = '0; dl_vec = '0;
    sb.delete();
    exp_spur = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // First high sample; inputs are scrambled afterwards to catch re-capture
  task automatic start_event(input logic [PN-1:0] org, input logic [PN-1:0] vec, input bit logged);
    exp_t e;
    dl = 1'b1; origin = org; dl_vec = vec;
    if (logged) begin
      e.idx = low_idx(org);
      e.vec = vec;
      e.ts  = tb_cyc;
      sb.push_back(e);
    end
    tick(1);
    origin = ~org;
    dl_vec = ~vec;
  endtask

  task automatic full_event(input logic [PN-1:0] org, input logic [PN-1:0] vec, input bit logged);
    start_event(org, vec, logged);
    tick(CC - 1);
    dl = 1'b0;
    tick(1);
  endtask

  // Compare the FIFO head against the scoreboard front, then pop it
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".valid"}, 64'(rd_valid), 64'd1);
    chk({tag, ".idx"},   64'(rd_idx),   64'(e.idx));
    chk({tag, ".vec"},   64'(rd_vec),   64'(e.vec));
    chk({tag, ".ts"},    64'(rd_ts),    64'(e.ts));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    dl = 1'b0; tc = 1'b0; rd_en = 1'b0; origin = '0; dl_vec = '0;
    tick(3);
    chk("rst.stop",  64'(stop),      64'd0);
    chk("rst.valid", 64'(rd_valid),  64'd0);
    chk("rst.count", 64'(log_count), 64'd0);
    chk("rst.ovf",   64'(ovf),       64'd0);
    chk("rst.oerr",  64'(oerr),      64'd0);
    chk("rst.spur",  64'(spur),      64'd0);
    chk("rst.ts",    64'(rd_ts),     64'd0);
    rst = 1'b0;
    tick(2);

    // Basic confirmation latency and head contents
    start_event(2'b10, 2'b11, 1'b1);
    tick(CC - 2);
    chk("t1.stop_early",  64'(stop),     64'd0);
    chk("t1.valid_early", 64'(rd_valid), 64'd0);
    tick(1);
    chk("t1.stop",  64'(stop),      64'd1);
    chk("t1.count", 64'(log_count), 64'd1);
    tc = 1'b1;
    tick(1);
    tc = 1'b0;
    chk("t1.stop_tc", 64'(stop), 64'd1);
    dl = 1'b0;
    tick(1);
    chk("t1.stop_fall", 64'(stop), 64'd0);
    pop_check("t1");
    chk("t1.count_empty", 64'(log_count), 64'd0);
    chk("t1.vec_empty",   64'(rd_vec),    64'd0);

    // Candidate abandoned after 5 high samples
    start_event(2'b01, 2'b01, 1'b0);
    tick(4);
    chk("t2.stop_mid", 64'(stop), 64'd0);
    dl = 1'b0;
    tick(1);
    exp_spur++;
    chk("t2.spur",  64'(spur),      64'(exp_spur));
    chk("t2.count", 64'(log_count), 64'd0);

    // token_clear during pending aborts the candidate
    start_event(2'b10, 2'b01, 1'b0);
    tick(6);
    tc = 1'b1;
    tick(1);
    tc = 1'b0;
    dl = 1'b0;
    exp_spur++;
    tick(1);
    chk("t3.spur",  64'(spur),      64'(exp_spur));
    chk("t3.stop",  64'(stop),      64'd0);
    chk("t3.count", 64'(log_count), 64'd0);
    chk("t3.oerr",  64'(oerr),      64'd0);

    // Origin errors: none set, then two bits set
    full_event(2'b00, 2'b01, 1'b1);
    chk("t4.oerr_zero", 64'(oerr), 64'd1);
    pop_check("t4a");
    do_reset();
    chk("t4.oerr_clr", 64'(oerr), 64'd0);
    full_event(2'b11, 2'b10, 1'b1);
    chk("t4.oerr_multi", 64'(oerr), 64'd1);
    pop_check("t4b");

    // Nine events into an eight-deep log with no reads
    do_reset();
    for (int k = 0; k < 9; k++) begin
      full_event((k % 2 == 1) ? 2'b10 : 2'b01, 2'(k + 1), k < 8);
    end
    chk("t5.count", 64'(log_count), 64'd8);
    chk("t5.ovf",   64'(ovf),       64'd1);
    for (int k = 0; k < 8; k++) pop_check("t5");
    chk("t5.count_empty", 64'(log_count), 64'd0);
    chk("t5.ovf_sticky",  64'(ovf),       64'd1);

    // Ninth push coincides with a pop: no overflow
    do_reset();
    for (int k = 0; k < 8; k++) begin
      full_event((k % 2 == 0) ? 2'b10 : 2'b01, 2'(k), 1'b1);
    end
    start_event(2'b01, 2'b11, 1'b1);
    tick(CC - 2);
    pop_check("t5b.pushpop");
    chk("t5b.ovf",   64'(ovf),       64'd0);
    chk("t5b.count", 64'(log_count), 64'd8);
    chk("t5b.stop",  64'(stop),      64'd1);
    dl = 1'b0;
    tick(1);
    for (int k = 0; k < 8; k++) pop_check("t5b");

    // Asynchronous reset while confirmed with three entries logged
    do_reset();
    full_event(2'b01, 2'b01, 1'b1);
    start_event(2'b01, 2'b01, 1'b0);
    tick(2);
    dl = 1'b0;
    tick(1);
    exp_spur++;
    full_event(2'b00, 2'b10, 1'b1);
    start_event(2'b10, 2'b11, 1'b1);
    tick(CC - 1);
    chk("t6.count_pre", 64'(log_count), 64'd3);
    chk("t6.stop_pre",  64'(stop),      64'd1);
    chk("t6.oerr_pre",  64'(oerr),      64'd1);
    chk("t6.spur_pre",  64'(spur),      64'(exp_spur));
    #2;
    rst = 1'b1;
    #1;
    chk("t6.stop",  64'(stop),      64'd0);
    chk("t6.valid", 64'(rd_valid),  64'd0);
    chk("t6.count", 64'(log_count), 64'd0);
    chk("t6.oerr",  64'(oerr),      64'd0);
    chk("t6.spur",  64'(spur),      64'd0);
    chk("t6.ovf",   64'(ovf),       64'd0);
    tick(1);
    dl = 1'b0;
    sb.delete();
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aesl_deadlock_event_recorder.md
# aesl_deadlock_event_recorder

Downstream consumer of the deadlock report path. It watches the global deadlock flag, the per-process detect vector, the origin one-hot and the token-clear pulse. A deadlock is confirmed only after the flag stays high for a programmable number of cycles. Each confirmed event is logged, with a timestamp and a process snapshot, into a small FIFO that the simulation testbench drains. The block also raises a stop request the testbench uses to end the run cleanly.

## Interface
- PROC_NUM, 2, number of monitored processes (≥1)
- LOG_DEPTH, 8, event FIFO entries (power of two, ≥2)
- CONFIRM_CYCLES, 16, consecutive high samples of dl_detect_out required to confirm (≥2)
- TS_W, 32, timestamp width
- IDX_W, derived $clog2(PROC_NUM) (min 1), origin index width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared
- dl_in_vec  in  PROC_NUM  per-process deadlock-detect vector
- dl_detect_out  in  1  global deadlock flag
- origin  in  PROC_NUM  one-hot origin of current deadlock
- token_clear  in  1  detection token cleared; aborts an unconfirmed event
- rd_en  in  1  pop request
- rd_valid  out  1  FIFO non-empty (first-word-fall-through)
- rd_origin_idx  out  IDX_W  head entry origin index
- rd_dl_vec  out  PROC_NUM  head entry dl_in_vec snapshot
- rd_timestamp  out  TS_W  head entry cycle stamp
- log_count  out  $clog2(LOG_DEPTH)+1  entries held
- stop_req  out  1  confirmed deadlock active
- overflow  out  1  sticky: confirmed event dropped, FIFO full
- origin_err  out  1  sticky: origin not one-hot at capture
- spurious_cnt  out  8  aborted candidates, saturating at 255

## Operation
- Free-running counter ts: resets to 0, increments every cycle, wraps modulo 2^TS_W.
- FSM states:
  - IDLE (reset state)
    - dl_detect_out=1 → PENDING, cnt←1.
    - Capture ts, dl_in_vec and the encoded origin.
  - PENDING
    - dl_detect_out=0 or token_clear=1 → IDLE, spurious_cnt+1 (saturating).
    - Otherwise, with cnt==CONFIRM_CYCLES-1 → CONFIRMED; push the captured entry.
    - Otherwise cnt+1.
  - CONFIRMED
    - stop_req=1.
    - dl_detect_out=0 → IDLE. token_clear is ignored in this state.
- Origin encoding:
  - rd_origin_idx is the index of the lowest set bit.
  - If origin is zero or has more than one bit set, set origin_err. The index is the lowest set bit, or 0 if none.
- Capture uses the values present in the IDLE→PENDING sample cycle. Later changes during PENDING are not re-captured.
- FIFO push/pop rules:
  - Push while full without a same-cycle pop: entry dropped, overflow set.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - rd_en while empty: ignored.
- Reset mid-event: FSM returns to IDLE; FIFO, counters and sticky flags clear; stop_req drops asynchronously.

## Timing
- Reset values:
  - All outputs 0.
  - rd_* fields 0 while empty.
- Confirmation latency:
  - Edge 0 is the first edge sampling dl_detect_out=1 in IDLE.
  - stop_req, rd_valid and the log_count increment become visible after edge CONFIRM_CYCLES-1, i.e. after CONFIRM_CYCLES consecutive high samples.
- stop_req falls one edge after dl_detect_out is sampled low in CONFIRMED.
- Back-to-back events:
  - A new candidate may start on the edge after the return to IDLE.
  - dl_detect_out must be sampled 0 at least once between events.
- Pop: the head advances on the edge sampling rd_en=1 with rd_valid=1. The new head is visible next cycle.
- Flags:
  - log_count is registered and updates on the same edge as push/pop.
  - overflow and origin_err set on the offending edge and stay set until reset.

## Structure
- Package aesl_deadlock_pkg holds:
  - the FSM state enum (IDLE, PENDING, CONFIRMED)
  - the event entry struct (origin_idx, dl_vec, timestamp)
  - parameter defaults
- Sub-module aesl_dl_event_fifo:
  - synchronous FWFT FIFO of entry structs
  - ports: push, pop, full, empty, count
- Top holds the FSM, confirm counter, timestamp counter, origin encoder and the sticky flags.

## Test plan
- Reset, then dl_detect_out=1 held, origin=2'b10, dl_in_vec=2'b11, CONFIRM_CYCLES=16 → stop_req rises after the 16th high sample. Head entry: origin_idx=1, dl_vec=2'b11, timestamp=cycle of first sample.
- dl_detect_out high for 5 cycles, then low → no push, spurious_cnt=1, stop_req never asserts.
- token_clear pulse at PENDING cycle 7 → return to IDLE, spurious_cnt increments. A token_clear in CONFIRMED → stop_req stays high.
- 9 confirmed events with LOG_DEPTH=8 and no reads → log_count=8, overflow=1, first 8 entries intact in order. With rd_en asserted in the 9th push cycle → no overflow.
- origin=2'b00 at capture → origin_err=1, origin_idx=0. origin=2'b11 → origin_idx=0, origin_err=1.
- Reset asserted while in CONFIRMED with 3 entries logged → immediately stop_req=0, rd_valid=0, log_count=0, flags cleared.
